// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: operation codes and controller states.
package mc_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_LSH     = 3'b001,
        OP_RSH     = 3'b010,
        OP_XOR     = 3'b011,
        OP_SUB     = 3'b100,
        OP_AND     = 3'b101,
        OP_MUL     = 3'b110,
        OP_ADD_ALT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MUL,
        S_DONE
    } state_e;

endpackage

// File: rtl/mc_alu_core.sv
// Single-cycle ALU slice: ADD/SUB/XOR/AND with carry, parity and zero flags.
module mc_alu_core
    import mc_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] r,
    output logic         co,
    output logic         pari,
    output logic         zero
);

    logic [W:0] sum;

    // Non-arithmetic codes pass a through with no carry (zero-count shifts rely on this).
    always_comb begin
        sum = '0;
        r   = a;
        co  = 1'b0;
        case (op_e'(op))
            OP_ADD, OP_ADD_ALT: begin
                sum       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
                {co, r}   = sum;
            end
            OP_SUB: begin
                sum       = {1'b0, b} - {1'b0, a} + {{W{1'b0}}, ci};
                {co, r}   = sum;
            end
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            default: ;
        endcase
        pari = ^r;
        zero = (r == '0);
    end

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops via mc_alu_core, bit-serial shifts and
// an iterative shift-add multiplier sequenced by one FSM.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    input  logic         sc_i,
    output logic         done,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic         sc_o,
    output logic         pari,
    output logic         zero
);

    state_e         state;
    op_e            op_d;
    logic [SW-1:0]  n_in, cnt;
    logic           idle, is_shift, accept, finish;

    logic [W-1:0]   sr_q, a_q;
    logic           fill_q, left_q;
    logic [2*W-1:0] p_q, p_in, p_nx;

    logic [W-1:0]   sh_in, sh_r, a_m;
    logic           sh_c, sh_fill, sh_left;
    logic [W:0]     hi_sum;

    logic [W-1:0]   core_r;
    logic           core_co, core_pari, core_zero;
    logic [W-1:0]   fin_r, fin_hi;
    logic           fin_c, fin_pari, fin_zero;

    assign op_d     = op_e'(op);
    assign n_in     = inB[SW-1:0];
    assign idle     = (state == S_IDLE);
    assign is_shift = (op_d == OP_LSH) || (op_d == OP_RSH);
    assign accept   = start && ready;

    mc_alu_core #(.W(W)) u_core (
        .op   (op),
        .a    (inA),
        .b    (inB),
        .ci   (sc_i),
        .r    (core_r),
        .co   (core_co),
        .pari (core_pari),
        .zero (core_zero)
    );

    // The first shift / multiply step runs on the accept edge straight from the
    // inputs, so an n-step operation reaches DONE exactly n edges after accept.
    always_comb begin
        sh_in   = idle ? inA  : sr_q;
        sh_fill = idle ? sc_i : fill_q;
        sh_left = idle ? (op_d == OP_LSH) : left_q;
        if (sh_left) {sh_c, sh_r} = {sh_in, sh_fill};
        else         {sh_r, sh_c} = {sh_fill, sh_in};

        p_in   = idle ? {{W{1'b0}}, inB} : p_q;
        a_m    = idle ? inA : a_q;
        hi_sum = {1'b0, p_in[2*W-1:W]} + (p_in[0] ? {1'b0, a_m} : {(W+1){1'b0}});
        p_nx   = {hi_sum, p_in[W-1:1]};
    end

    always_comb begin
        fin_r    = core_r;
        fin_hi   = '0;
        fin_c    = core_co;
        fin_pari = core_pari;
        fin_zero = core_zero;
        if (state == S_SHIFT || (idle && is_shift && n_in != '0)) begin
            fin_r    = sh_r;
            fin_c    = sh_c;
            fin_pari = ^sh_r;
            fin_zero = (sh_r == '0);
        end else if (state == S_MUL || (idle && op_d == OP_MUL)) begin
            fin_r    = p_nx[W-1:0];
            fin_hi   = p_nx[2*W-1:W];
            fin_c    = |p_nx[2*W-1:W];
            fin_pari = ^p_nx[W-1:0];
            fin_zero = (p_nx == '0);
        end

        finish = 1'b0;
        case (state)
            S_IDLE:           finish = accept && (op_d != OP_MUL) &&
                                       !(is_shift && n_in > SW'(1));
            S_SHIFT, S_MUL:   finish = (cnt == SW'(1));
            default:          finish = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            cnt     <= '0;
            sr_q    <= '0;
            a_q     <= '0;
            p_q     <= '0;
            fill_q  <= 1'b0;
            left_q  <= 1'b0;
            rslt    <= '0;
            rslt_hi <= '0;
            sc_o    <= 1'b0;
            pari    <= 1'b0;
            zero    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (finish) begin
                state   <= S_DONE;
                ready   <= 1'b0;
                done    <= 1'b1;
                cnt     <= '0;
                rslt    <= fin_r;
                rslt_hi <= fin_hi;
                sc_o    <= fin_c;
                pari    <= fin_pari;
                zero    <= fin_zero;
            end else begin
                case (state)
                    S_IDLE: if (accept) begin
                        ready  <= 1'b0;
                        sr_q   <= sh_r;
                        p_q    <= p_nx;
                        a_q    <= inA;
                        fill_q <= sc_i;
                        left_q <= (op_d == OP_LSH);
                        if (op_d == OP_MUL) begin
                            state <= S_MUL;
                            cnt   <= SW'(W - 1);
                        end else begin
                            state <= S_SHIFT;
                            cnt   <= n_in - SW'(1);
                        end
                    end
                    S_SHIFT: begin
                        sr_q <= sh_r;
                        cnt  <= cnt - SW'(1);
                    end
                    S_MUL: begin
                        p_q <= p_nx;
                        cnt <= cnt - SW'(1);
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu (W=8): expected results queued at accept, checked on done.
module tb_mc_alu;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]    r;
        logic [W-1:0]    hi;
        logic            c;
        logic            p;
        logic            z;
        longint unsigned due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic         sc_i = 1'b0;
    logic         ready, done, sc_o, pari, zero;
    logic [W-1:0] rslt, rslt_hi;

    exp_t            q[$];
    int              checks = 0;
    int              errors = 0;
    longint unsigned cyc = 0;

    mc_alu #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ready   (ready),
        .op      (op),
        .inA     (inA),
        .inB     (inB),
        .sc_i    (sc_i),
        .done    (done),
        .rslt    (rslt),
        .rslt_hi (rslt_hi),
        .sc_o    (sc_o),
        .pari    (pari),
        .zero    (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, output exp_t e, output int lat);
        logic [W:0]     s;
        logic [2*W-1:0] prod;
        logic [W-1:0]   mask;
        int             n;
        n    = int'(b[2:0]);
        mask = W'((1 << n) - 1);
        prod = '0;
        e.r  = '0;
        e.hi = '0;
        e.c  = 1'b0;
        e.due = 0;
        lat  = 1;
        case (o)
            3'd0, 3'd7: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci}; e.r = s[W-1:0]; e.c = s[W]; end
            3'd4:       begin s = {1'b0, b} - {1'b0, a} + {{W{1'b0}}, ci}; e.r = s[W-1:0]; e.c = s[W]; end
            3'd3:       e.r = a ^ b;
            3'd5:       e.r = a & b;
            3'd1: begin
                e.r = a;
                if (n != 0) begin e.r = W'(a << n) | (ci ? mask : '0); e.c = a[W-n]; lat = n; end
            end
            3'd2: begin
                e.r = a;
                if (n != 0) begin e.r = (a >> n) | (ci ? ~(8'hFF >> n) : '0); e.c = a[n-1]; lat = n; end
            end
            default: begin
                prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.r  = prod[W-1:0];
                e.hi = prod[2*W-1:W];
                e.c  = |prod[2*W-1:W];
                lat  = W;
            end
        endcase
        e.p = ^e.r;
        e.z = (o == 3'd6) ? (prod == '0) : (e.r == '0);
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t e;
        int   lat;
        int   waitc = 0;
        @(negedge clk);
        while (!ready && waitc < 100) begin @(negedge clk); waitc++; end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: ready=%b required 1", ready);
            return;
        end
        op = o; inA = a; inB = b; sc_i = ci; start = 1'b1;
        @(posedge clk); #1;
        model(o, a, b, ci, e, lat);
        e.due = cyc + longint'(lat) - 1;
        q.push_back(e);
        start = 1'b0;
        op = 3'($urandom); inA = W'($urandom); inB = W'($urandom); sc_i = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: done=1 required 0 at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    checks += 5;
                    if (cyc !== e.due) begin errors++; $display("FAIL sb_latency: done cycle=%0d required %0d", cyc, e.due); end
                    if (rslt !== e.r) begin errors++; $display("FAIL sb_rslt: rslt=%h required %h", rslt, e.r); end
                    if (rslt_hi !== e.hi) begin errors++; $display("FAIL sb_rslt_hi: rslt_hi=%h required %h", rslt_hi, e.hi); end
                    if (sc_o !== e.c) begin errors++; $display("FAIL sb_sc_o: sc_o=%b required %b", sc_o, e.c); end
                    if ({pari, zero} !== {e.p, e.z}) begin
                        errors++;
                        $display("FAIL sb_flags: pari,zero=%b%b required %b%b", pari, zero, e.p, e.z);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 2;
        if ({ready, done, sc_o, pari, zero} !== 5'b10001) begin
            errors++;
            $display("FAIL reset_flags: ready,done,sc_o,pari,zero=%b required 10001", {ready, done, sc_o, pari, zero});
        end
        if ({rslt_hi, rslt} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: {rslt_hi,rslt}=%h required 0000", {rslt_hi, rslt});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        issue(3'd0, 8'hF0, 8'h20, 1'b1);
        drain();
        checks++;
        if ({rslt, sc_o, zero, pari} !== {8'h11, 3'b100}) begin
            errors++;
            $display("FAIL add_hold: rslt,sc_o,zero,pari=%h,%b%b%b required 11,100", rslt, sc_o, zero, pari);
        end
        issue(3'd4, 8'h05, 8'h05, 1'b0);
        issue(3'd4, 8'h07, 8'h03, 1'b1);
        issue(3'd3, 8'hA5, 8'h0F, 1'b1);
        issue(3'd5, 8'hA5, 8'h3C, 1'b1);
        issue(3'd7, 8'hFF, 8'h01, 1'b0);
        drain();
    endtask

    task automatic test_shift();
        issue(3'd1, 8'h81, 8'h03, 1'b0);
        issue(3'd2, 8'h81, 8'h01, 1'b1);
        issue(3'd2, 8'h81, 8'h07, 1'b1);
        issue(3'd1, 8'h81, 8'hF7, 1'b1);
        issue(3'd1, 8'h81, 8'h00, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        checks++;
        if ({rslt, sc_o, done} !== {8'h81, 2'b00}) begin
            errors++;
            $display("FAIL shift_hold: rslt,sc_o,done=%h,%b%b required 81,00", rslt, sc_o, done);
        end
    endtask

    task automatic test_mul();
        issue(3'd6, 8'hFF, 8'hFF, 1'b0);
        drain();
        checks++;
        if ({rslt_hi, rslt, sc_o, zero} !== {16'hFE01, 2'b10}) begin
            errors++;
            $display("FAIL mul_ff: hi,lo,sc_o,zero=%h%h,%b%b required FE01,10", rslt_hi, rslt, sc_o, zero);
        end
        issue(3'd6, 8'h00, 8'hFF, 1'b1);
        issue(3'd6, 8'h10, 8'h10, 1'b0);
        issue(3'd6, 8'h0D, 8'h0B, 1'b0);
        drain();
    endtask

    task automatic test_busy();
        bit seen = 0;
        issue(3'd6, 8'h0D, 8'h0B, 1'b0);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready_mul: ready=%b required 0", ready); end
        end
        @(negedge clk);
        op = 3'd0; inA = 8'h01; inB = 8'h01; sc_i = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: ready=%b required 0", ready); end
            if (done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        drain();
        checks++;
        if ({ready, rslt_hi, rslt} !== {1'b1, 16'h008F}) begin
            errors++;
            $display("FAIL busy_result: ready,hi,lo=%b,%h%h required 1,008F", ready, rslt_hi, rslt);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        issue(3'd6, 8'hFF, 8'hFF, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, done, rslt_hi, rslt, sc_o, pari, zero} !== {2'b10, 16'h0000, 3'b001}) begin
            errors++;
            $display("FAIL abort_clear: ready,done,hi,lo,sc,p,z=%b%b,%h%h,%b%b%b required 10,0000,001",
                     ready, done, rslt_hi, rslt, sc_o, pari, zero);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        op = 3'd0; inA = 8'h12; inB = 8'h34; sc_i = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        model(3'd0, 8'h12, 8'h34, 1'b0, e, lat);
        e.due = cyc + longint'(lat) - 1;
        q.push_back(e);
        start = 1'b0;
        drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        model(3'd0, 8'h3C, 8'h0F, 1'b1, e, lat);
        op = 3'd0; inA = 8'h3C; inB = 8'h0F; sc_i = 1'b1; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i % 2 == 0) begin e.due = cyc; q.push_back(e); end
            @(negedge clk);
            checks++;
            if (done !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_done: edge %0d done=%b required %b", i, done, (i % 2 == 0));
            end
        end
        start = 1'b0;
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            issue(3'($urandom), W'($urandom), W'($urandom), 1'($urandom));
        drain();
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_add_sub();
        test_shift();
        test_mul();
        test_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
